// File: rtl/riscv_config_pkg.sv
// Core-wide defaults for the multi-cycle divider.
package riscv_config_pkg;

  // Nominal divider latency from start to done, in cycles.
  localparam int unsigned DEFAULT_DIV_LATENCY = 4;
  // Watchdog limit for one divide; must exceed the divider latency.
  localparam int unsigned DEFAULT_DIV_TIMEOUT = 64;

endpackage

// File: rtl/riscv_exception_pkg.sv
// Exception cause codes shared by the execute-stage functional units.
package riscv_exception_pkg;

  localparam logic [31:0] CAUSE_ILLEGAL_INSTRUCTION = 32'd2;

endpackage

// File: rtl/riscv_types_pkg.sv
// Shared RV32M divider types: funct3 op codes and the issue-controller state encoding.
package riscv_types_pkg;

  // funct3 encodings of the RV32M divide/remainder instructions.
  typedef enum logic [2:0] {
    DIV_OP_DIV  = 3'b100,
    DIV_OP_DIVU = 3'b101,
    DIV_OP_REM  = 3'b110,
    DIV_OP_REMU = 3'b111
  } div_op_e;

  // States of the divider issue controller.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } div_issue_state_e;

endpackage

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: initiator side of the multi-cycle divider start/done handshake.
// Takes one DIV/DIVU/REM/REMU request at a time, pulses start with held operands,
// waits for done (with a watchdog) and returns the result over valid/ready.
// Build macro DIV_ISSUE_FASTPATH_EN: resolve divide-by-zero and signed overflow
// at accept time and answer without starting the divider.
module div_issue_ctrl
  import riscv_types_pkg::*;
  import riscv_exception_pkg::*;
  import riscv_config_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TAG_WIDTH      = 5,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_DIV_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_op_i,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  input  logic                  flush_i,
  output logic                  div_start_o,
  output logic [2:0]            div_op_o,
  output logic [DATA_WIDTH-1:0] div_a_o,
  output logic [DATA_WIDTH-1:0] div_b_o,
  input  logic [DATA_WIDTH-1:0] div_result_i,
  input  logic                  div_done_i,
  input  logic                  div_exc_valid_i,
  input  logic [31:0]           div_exc_cause_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic [TAG_WIDTH-1:0]  rsp_tag_o,
  output logic                  rsp_exc_valid_o,
  output logic [31:0]           rsp_exc_cause_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value in the last cycle the watchdog still allows.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  div_issue_state_e      state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  exc_valid_q, exc_valid_d;
  logic [31:0]           exc_cause_q, exc_cause_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

`ifdef DIV_ISSUE_FASTPATH_EN
  // Operand patterns the divider would flag anyway: b == 0, or signed MIN / -1.
  function automatic logic fast_hit(input logic [2:0] op,
                                    input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
    logic ovf;
    ovf = !op[0] && (a == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (&b);
    return (b == '0) || ovf;
  endfunction

  // Architectural result for those patterns (op[1] selects REM/REMU).
  function automatic logic [DATA_WIDTH-1:0] fast_result(input logic [2:0] op,
                                                        input logic [DATA_WIDTH-1:0] a,
                                                        input logic [DATA_WIDTH-1:0] b);
    if (b == '0) return op[1] ? a : '1;
    return op[1] ? '0 : a;
  endfunction
`endif

  // Next-state and datapath-register logic for the issue FSM.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    result_d    = result_q;
    exc_valid_d = exc_valid_q;
    exc_cause_d = exc_cause_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        // A flush in the accept cycle kills the request before it is taken.
        if (req_valid_i && !flush_i) begin
          op_d  = req_op_i;
          a_d   = req_a_i;
          b_d   = req_b_i;
          tag_d = req_tag_i;
`ifdef DIV_ISSUE_FASTPATH_EN
          if (fast_hit(req_op_i, req_a_i, req_b_i)) begin
            result_d    = fast_result(req_op_i, req_a_i, req_b_i);
            exc_valid_d = 1'b1;
            exc_cause_d = CAUSE_ILLEGAL_INSTRUCTION;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
`else
          state_d = ST_ISSUE;
`endif
        end
      end

      ST_ISSUE: begin
        // The divider cannot be aborted, so a flush here still starts it and drains.
        cnt_d   = '0;
        state_d = flush_i ? ST_DRAIN : ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (div_done_i) begin
          if (flush_i) begin
            state_d = ST_IDLE;
          end else begin
            result_d    = div_result_i;
            exc_valid_d = div_exc_valid_i;
            exc_cause_d = div_exc_cause_i;
            state_d     = ST_RESP;
          end
        end else if (flush_i) begin
          state_d = ST_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          result_d    = '0;
          exc_valid_d = 1'b1;
          exc_cause_d = CAUSE_ILLEGAL_INSTRUCTION;
          timeout_d   = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (div_done_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_RESP: begin
        // Flush and ready both retire the response; either way back to IDLE.
        if (flush_i || rsp_ready_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand, response, counter and sticky-timeout registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the operand and response registers are reset along with the FSM so
      // every output reads 0 after reset, not just the control bits.
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      result_q    <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      result_q    <= result_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign req_ready_o     = (state_q == ST_IDLE);
  assign busy_o          = (state_q != ST_IDLE);
  assign div_start_o     = (state_q == ST_ISSUE);
  assign rsp_valid_o     = (state_q == ST_RESP);
  assign div_op_o        = op_q;
  assign div_a_o         = a_q;
  assign div_b_o         = b_q;
  assign rsp_result_o    = result_q;
  assign rsp_tag_o       = tag_q;
  assign rsp_exc_valid_o = exc_valid_q;
  assign rsp_exc_cause_o = exc_cause_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Testbench for div_issue_ctrl: behavioural divider with fixed latency, response
// scoreboard, and directed flush/timeout/reset/back-pressure scenarios.
module tb_div_issue_ctrl;
  import riscv_types_pkg::*;
  import riscv_exception_pkg::*;
  import riscv_config_pkg::*;

  localparam int DW = 32;
  localparam int TW = 5;
  localparam int L  = DEFAULT_DIV_LATENCY;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i, req_ready_o;
  logic [2:0]    req_op_i;
  logic [DW-1:0] req_a_i, req_b_i;
  logic [TW-1:0] req_tag_i;
  logic          flush_i;
  logic          div_start_o;
  logic [2:0]    div_op_o;
  logic [DW-1:0] div_a_o, div_b_o;
  logic [DW-1:0] div_result_i;
  logic          div_done_i, div_exc_valid_i;
  logic [31:0]   div_exc_cause_i;
  logic          rsp_valid_o, rsp_ready_i;
  logic [DW-1:0] rsp_result_o;
  logic [TW-1:0] rsp_tag_o;
  logic          rsp_exc_valid_o;
  logic [31:0]   rsp_exc_cause_o;
  logic          busy_o, timeout_o;

  div_issue_ctrl #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i), .flush_i(flush_i),
    .div_start_o(div_start_o), .div_op_o(div_op_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_result_i(div_result_i), .div_done_i(div_done_i),
    .div_exc_valid_i(div_exc_valid_i), .div_exc_cause_i(div_exc_cause_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_tag_o(rsp_tag_o), .rsp_exc_valid_o(rsp_exc_valid_o),
    .rsp_exc_cause_o(rsp_exc_cause_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // RV32M reference, including the divider's exception cases.
  function automatic void ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic exc);
    exc = 1'b0;
    if (b == 32'd0) begin
      exc = 1'b1;
      res = op[1] ? a : 32'hFFFF_FFFF;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      exc = 1'b1;
      res = op[1] ? 32'd0 : a;
    end else begin
      case (op)
        3'b100:  res = $signed(a) / $signed(b);
        3'b101:  res = a / b;
        3'b110:  res = $signed(a) % $signed(b);
        default: res = a % b;
      endcase
    end
  endfunction

  // Divider model: done is asserted for one cycle, L cycles after the start cycle.
  logic          model_hang = 1'b0;
  int            model_cnt  = 0;
  logic [2:0]    m_op;
  logic [31:0]   m_a, m_b, m_res;
  logic          m_exc;

  always @(negedge clk_i) begin
    div_done_i      = 1'b0;
    div_exc_valid_i = 1'b0;
    div_exc_cause_i = 32'd0;
    div_result_i    = 32'hDEAD_BEEF;
    if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0 && !model_hang) begin
        ref_div(m_op, m_a, m_b, m_res, m_exc);
        div_done_i      = 1'b1;
        div_result_i    = m_res;
        div_exc_valid_i = m_exc;
        div_exc_cause_i = m_exc ? CAUSE_ILLEGAL_INSTRUCTION : 32'd0;
      end
    end
    if (div_start_o) begin
      model_cnt = L;
      m_op      = div_op_o;
      m_a       = div_a_o;
      m_b       = div_b_o;
    end
  end

  // Scoreboard of expected responses.
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  tag;
    logic        exc;
    logic [31:0] cause;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t exp_e;
  int   rsp_count   = 0;
  int   start_count = 0;

  always @(negedge clk_i) begin
    if (rst_ni && div_start_o) start_count++;
    if (rst_ni && rsp_valid_o && rsp_ready_i && !flush_i) begin
      rsp_count++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("sb_result", rsp_result_o, exp_e.result);
        check("sb_tag", rsp_tag_o, exp_e.tag);
        check("sb_exc", rsp_exc_valid_o, exp_e.exc);
        check("sb_cause", rsp_exc_cause_o, exp_e.cause);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
    logic [31:0] r;
    logic        e;
    ref_div(op, a, b, r, e);
    exp_q.push_back('{result: r, tag: tag, exc: e,
                      cause: (e ? CAUSE_ILLEGAL_INSTRUCTION : 32'd0)});
  endtask

  // Present a request for one cycle; returns in the cycle after the accept edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_tag_i   = tag;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!rsp_valid_o && n < max) begin
      tick();
      n++;
    end
    if (!rsp_valid_o) check("wait_rsp_expired", 0, 1);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy_o && n < max) begin
      tick();
      n++;
    end
    check("wait_idle", busy_o, 0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
    push_exp(op, a, b, tag);
    send(op, a, b, tag);
    wait_idle(60);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got=running expected=finished");
    $fatal(1, "time limit");
  end

  int n, s0, c0, exp_lat, exp_starts;

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
    req_tag_i = '0; flush_i = 1'b0; rsp_ready_i = 1'b1;
    repeat (3) tick();
    check("rst_req_ready", req_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_start", div_start_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_div_a", div_a_o, 0);
    check("rst_rsp_result", rsp_result_o, 0);
    rst_ni = 1'b1;
    tick();

    // DIVU 100/7: single start pulse, response L+1 cycles after the ISSUE cycle.
    s0 = start_count;
    push_exp(DIV_OP_DIVU, 32'd100, 32'd7, 5'd3);
    send(DIV_OP_DIVU, 32'd100, 32'd7, 5'd3);
    check("t1_start_issue", div_start_o, 1);
    check("t1_req_ready_low", req_ready_o, 0);
    check("t1_div_a", div_a_o, 100);
    check("t1_div_b", div_b_o, 7);
    check("t1_div_op", div_op_o, DIV_OP_DIVU);
    tick();
    check("t1_start_gone", div_start_o, 0);
    wait_rsp(20, n);
    check("t1_latency", n, L);
    check("t1_result", rsp_result_o, 14);
    check("t1_tag", rsp_tag_o, 3);
    check("t1_exc", rsp_exc_valid_o, 0);
    tick();
    check("t1_start_once", start_count - s0, 1);
    check("t1_idle", req_ready_o, 1);

    // REM -7 % 2 with 5 cycles of back-pressure.
    rsp_ready_i = 1'b0;
    push_exp(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd9);
    send(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd9);
    wait_rsp(20, n);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", rsp_valid_o, 1);
      check("t2_hold_result", rsp_result_o, 32'hFFFF_FFFF);
      check("t2_hold_tag", rsp_tag_o, 9);
      check("t2_req_ready_low", req_ready_o, 0);
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    check("t2_idle_after_ready", req_ready_o, 1);
    check("t2_valid_dropped", rsp_valid_o, 0);

    // Flush in ISSUE: start still issued, drain until done, then accept again.
    c0 = rsp_count;
    s0 = start_count;
    send(DIV_OP_DIV, 32'd50, 32'd5, 5'd4);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("t3_busy_drain", busy_o, 1);
    repeat (3) tick();
    check("t3_busy_T5", busy_o, 1);
    check("t3_no_rsp_T5", rsp_valid_o, 0);
    tick();
    check("t3_idle_T6", req_ready_o, 1);
    push_exp(DIV_OP_DIV, 32'd20, 32'hFFFF_FFFD, 5'd6);
    send(DIV_OP_DIV, 32'd20, 32'hFFFF_FFFD, 5'd6);
    check("t3_next_accepted", div_start_o, 1);
    wait_idle(60);
    check("t3_one_rsp", rsp_count - c0, 1);
    check("t3_two_starts", start_count - s0, 2);

    // Flush in RESP drops the response even with ready high.
    c0 = rsp_count;
    rsp_ready_i = 1'b0;
    send(DIV_OP_DIVU, 32'd9, 32'd2, 5'd7);
    wait_rsp(20, n);
    flush_i = 1'b1;
    rsp_ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("t3b_rsp_dropped", rsp_valid_o, 0);
    check("t3b_idle", req_ready_o, 1);
    check("t3b_no_rsp", rsp_count - c0, 0);

    // Flush together with done: capture discarded, straight to IDLE.
    send(DIV_OP_REMU, 32'd9, 32'd4, 5'd8);
    repeat (4) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("t3c_idle", busy_o, 0);
    check("t3c_no_rsp", rsp_valid_o, 0);
    repeat (2) tick();
    check("t3c_still_no_rsp", rsp_valid_o, 0);
    check("t3c_no_rsp_count", rsp_count - c0, 0);

    // Random operations with random response back-pressure.
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'b100 | 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      push_exp(op, a, b, 5'(i));
      send(op, a, b, 5'(i));
      n = 0;
      while (busy_o && n < 60) begin
        rsp_ready_i = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      check("rand_done", busy_o, 0);
    end
    rsp_ready_i = 1'b1;

    // Signed overflow and divide-by-zero.
    s0 = start_count;
    push_exp(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    send(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    wait_rsp(20, n);
`ifdef DIV_ISSUE_FASTPATH_EN
    exp_lat = 0;
    exp_starts = 0;
`else
    exp_lat = L + 1;
    exp_starts = 1;
`endif
    check("t5_latency", n, exp_lat);
    check("t5_result", rsp_result_o, 32'h8000_0000);
    check("t5_exc", rsp_exc_valid_o, 1);
    check("t5_cause", rsp_exc_cause_o, CAUSE_ILLEGAL_INSTRUCTION);
    tick();
    check("t5_starts", start_count - s0, exp_starts);
    run_op(DIV_OP_DIVU, 32'd5, 32'd0, 5'd12);
    run_op(DIV_OP_REMU, 32'd5, 32'd0, 5'd13);
    run_op(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);

    // Watchdog: divider never answers.
    model_hang = 1'b1;
    exp_q.push_back('{result: 32'd0, tag: 5'd15, exc: 1'b1, cause: CAUSE_ILLEGAL_INSTRUCTION});
    send(DIV_OP_DIVU, 32'd10, 32'd3, 5'd15);
    wait_rsp(40, n);
    check("t6_latency", n, TO + 1);
    check("t6_timeout_flag", timeout_o, 1);
    check("t6_result", rsp_result_o, 0);
    check("t6_exc", rsp_exc_valid_o, 1);
    check("t6_cause", rsp_exc_cause_o, 2);
    tick();
    model_hang = 1'b0;
    repeat (2) tick();
    check("t6_timeout_sticky", timeout_o, 1);
    run_op(DIV_OP_DIVU, 32'd81, 32'd9, 5'd16);
    check("t6_timeout_sticky2", timeout_o, 1);

    // Reset during WAIT; the divider's late done must be ignored.
    c0 = rsp_count;
    send(DIV_OP_DIV, 32'd77, 32'd7, 5'd17);
    tick();
    check("t7_busy_wait", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    check("t7_rst_req_ready", req_ready_o, 1);
    check("t7_rst_busy", busy_o, 0);
    check("t7_rst_timeout", timeout_o, 0);
    check("t7_rst_div_a", div_a_o, 0);
    check("t7_rst_div_op", div_op_o, 0);
    check("t7_rst_rsp_tag", rsp_tag_o, 0);
    check("t7_rst_rsp_valid", rsp_valid_o, 0);
    tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    check("t7_no_rsp", rsp_valid_o, 0);
    check("t7_req_ready", req_ready_o, 1);
    check("t7_not_busy", busy_o, 0);
    check("t7_no_rsp_count", rsp_count - c0, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Initiator side of the multi-cycle divider start/done interface.
- Accepts RV32M DIV/DIVU/REM/REMU requests from the execute stage over valid/ready, issues them to the divider as a one-cycle start pulse with held operands, and waits for done.
- Returns the result, tag and exception over a valid/ready response channel.
- Handles pipeline flush, a watchdog timeout and back-pressure; one operation in flight at a time.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- TAG_WIDTH, 5, width of the request tag (destination register index).
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before the watchdog fires; must be greater than the divider latency.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready; high only in IDLE
- req_op_i  in  3  funct3 code: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_a_i  in  DATA_WIDTH  dividend
- req_b_i  in  DATA_WIDTH  divisor
- req_tag_i  in  TAG_WIDTH  request tag
- flush_i  in  1  kill the in-flight or pending operation
- div_start_o  out  1  one-cycle start pulse to the divider
- div_op_o  out  3  op code to the divider; registered, stable from ISSUE until the next accept
- div_a_o  out  DATA_WIDTH  dividend to the divider; registered, stable from ISSUE until the next accept
- div_b_o  out  DATA_WIDTH  divisor to the divider; registered, stable from ISSUE until the next accept
- div_result_i  in  DATA_WIDTH  divider result
- div_done_i  in  1  divider completion
- div_exc_valid_i  in  1  divider exception flag; sampled only with done
- div_exc_cause_i  in  32  divider exception cause
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_result_o  out  DATA_WIDTH  result
- rsp_tag_o  out  TAG_WIDTH  echoed tag
- rsp_exc_valid_o  out  1  exception present
- rsp_exc_cause_o  out  32  exception cause
- busy_o  out  1  state is not IDLE
- timeout_o  out  1  sticky watchdog flag; cleared only by reset

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready_o=1. Counter and the op/operand/tag/result registers are cleared to 0.
- Reset may occur mid-operation. After reset, any late div_done_i is ignored, because IDLE does not sample it.
- Clock/reset: clk_i, reset rst_ni, asynchronous, active-low.
- FSM states: IDLE, ISSUE, WAIT, DRAIN, RESP.
- IDLE:
  - Accept occurs when req_valid_i && req_ready_o && !flush_i at edge T. On accept, latch op, a, b and tag, then go to ISSUE.
  - If flush_i is high in the same cycle, the request is not accepted.
- ISSUE (cycle T+1):
  - div_start_o=1 for exactly one cycle; the counter clears; next state is WAIT.
  - If flush_i is high, the start is still issued, because the divider cannot be aborted; next state is DRAIN.
- WAIT:
  - The counter increments each cycle.
  - On div_done_i: capture result, exc_valid and exc_cause into the response registers, then go to RESP.
  - On flush_i without done: go to DRAIN.
  - On flush_i together with done: discard the capture and go to IDLE.
  - When the counter reaches TIMEOUT_CYCLES without done: go to RESP with result 0, rsp_exc_valid_o=1, cause CAUSE_ILLEGAL_INSTRUCTION, and timeout_o set.
  - Done in the same cycle as the timeout: done wins.
- DRAIN:
  - Wait for div_done_i, discard the result, go to IDLE.
  - The watchdog also applies here; on expiry go to IDLE and set timeout_o.
  - flush_i is ignored.
- RESP:
  - rsp_valid_o=1; response outputs are held stable while rsp_ready_i=0.
  - On rsp_ready_i: go to IDLE.
  - On flush_i: drop the response and go to IDLE; flush has priority over rsp_ready_i.
- Latency: with divider latency L, div_done_i is expected in T+1+L and rsp_valid_o rises in T+2+L.
- req_ready_o is combinational: (state==IDLE).
- Throughput: at most one op per L+3 cycles.
- div_done_i seen in IDLE, ISSUE or RESP is ignored.

Optional Feature:
- Macro: DIV_ISSUE_FASTPATH_EN.
- When defined, IDLE decodes special cases from req_a_i/req_b_i at accept, skips the divider and goes directly to RESP, with rsp_valid_o in T+1. rsp_exc_valid_o=1 and cause=CAUSE_ILLEGAL_INSTRUCTION in each case, matching the divider.
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM only): DIV gives a; REM gives 0.
- When not defined, every accepted request is issued to the divider.

Decomposition:
- riscv_types_pkg: div_op_e (funct3 codes) and the div_issue_state_e enum.
- riscv_exception_pkg: CAUSE_ILLEGAL_INSTRUCTION.
- riscv_config_pkg: DEFAULT_DIV_LATENCY and DEFAULT_DIV_TIMEOUT.
- No sub-module: the FSM, counter and response registers are a single module.
- The optional fast-path decode may live in a function inside the module.

Test Plan (divider model with L=4):
- DIVU a=100, b=7, tag=3, accept at T: div_start_o is high only in T+1; rsp_valid_o rises at T+6 with result 14, tag 3, exc 0.
- REM a=-7, b=2, with rsp_ready_i low for 5 cycles: outputs hold -1 stable, req_ready_o stays 0, then IDLE the cycle after ready.
- flush_i in ISSUE, done at T+5: no response is produced, busy_o=1 until T+6, and the next request is accepted at T+6.
- Model never asserts done, TIMEOUT_CYCLES=8: RESP with result 0, rsp_exc_valid_o=1, cause 2, and timeout_o stays 1 until reset.
- DIV a=0x80000000, b=0xFFFFFFFF: without the fast path, the result and exception come from the divider at T+6. With DIV_ISSUE_FASTPATH_EN, result 0x80000000 and exc 1 at T+1, and div_start_o is never asserted.
- rst_ni asserted during WAIT, then model done arrives 2 cycles later: all outputs are at reset values, no response is produced, and req_ready_o=1.
